// File: rtl/eth_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// eth_rx_frame_parser : parses the 16-byte RAMP header and heads the RX pipe
//   with rx_start/rx_data/rx_end messages; optional dst filter ETH_RX_MAC_FILTER_EN
// Revision: 1.0
// ============================================================================

package eth_rx_pipe_pkg;
  localparam logic [7:0] MACPID        = 8'hFE;
  localparam logic [7:0] rstPacketType = 8'h01;

  typedef enum logic [1:0] {
    rx_none  = 2'd0,
    rx_start = 2'd1,
    rx_data  = 2'd2,
    rx_end   = 2'd3
  } eth_rx_stype_e;

  typedef struct packed {
    logic [7:0]  ptype;
    logic [15:0] seqnum;
    logic [7:0]  pid;
  } eth_rx_hdr_t;

  typedef struct packed {
    eth_rx_stype_e stype;
    eth_rx_hdr_t   header;
    logic [31:0]   data;
  } eth_rx_pipe_data_type;
endpackage

module eth_rx_frame_parser
  import eth_rx_pipe_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_sof,
  input  logic                 rx_eof,
  input  logic                 rx_crc_err,
  input  logic [47:0]          mac_addr,
  input  logic                 mac_init,
  output eth_rx_pipe_data_type rx_pipe_out,
  output logic [15:0]          drop_count
);

  localparam logic [1:0]  st_idle    = 2'd0;
  localparam logic [1:0]  st_hdr     = 2'd1;
  localparam logic [1:0]  st_payload = 2'd2;
  localparam logic [1:0]  st_drain   = 2'd3;
  localparam logic [10:0] CNT_SAT    = 11'h7FF;
  localparam logic [10:0] MAX_CNT    = 11'(MAX_PAYLOAD);

  logic [1:0]           state_q, state_d;
  logic [10:0]          byte_cnt_q, byte_cnt_d;
  logic [47:0]          dst_q, dst_d;
  logic [7:0]           ptype_q, ptype_d;
  logic [15:0]          seqnum_q, seqnum_d;
  logic [31:0]          word_q, word_d;
  logic                 len_err_q, len_err_d;
  logic                 end_pend_q, end_pend_d;
  logic [31:0]          end_data_q, end_data_d;
  eth_rx_pipe_data_type out_q, out_d;
  logic [15:0]          drop_q, drop_d;
  logic [1:0]           drop_inc;
  logic [16:0]          drop_sum;
  logic [10:0]          cnt_inc;
  logic [31:0]          word_ins;
  logic                 filter_pass;

  assign cnt_inc  = (byte_cnt_q == CNT_SAT) ? CNT_SAT : byte_cnt_q + 11'd1;
  // Payload lane 0 lands in the top byte: big-endian word packing.
  assign word_ins = word_q | ({24'd0, rx_byte} << {~byte_cnt_q[1:0], 3'b000});

`ifdef ETH_RX_MAC_FILTER_EN
  assign filter_pass = (dst_q == mac_addr) || (dst_q == 48'hFFFF_FFFF_FFFF) ||
                       (!mac_init && (rx_byte == MACPID) && (ptype_q == rstPacketType));
`else
  logic unused_cfg;
  assign filter_pass = 1'b1;
  assign unused_cfg  = ^{mac_addr, mac_init, dst_q};
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    dst_d      = dst_q;
    ptype_d    = ptype_q;
    seqnum_d   = seqnum_q;
    word_d     = word_q;
    len_err_d  = len_err_q;
    end_pend_d = 1'b0;
    end_data_d = end_data_q;
    drop_inc   = 2'd0;
    out_d      = '0;

    if (end_pend_q) begin
      out_d.stype = rx_end;
      out_d.data  = end_data_q;
    end

    if (rx_valid) begin
      if (rx_sof) begin
        if (state_q == st_payload) begin
          out_d.stype = rx_end;
          out_d.data  = {5'd0, byte_cnt_q, 15'd0, 1'b1};
        end else if (state_q == st_hdr) begin
          drop_inc = 2'd1;
        end
        dst_d      = {40'd0, rx_byte};
        byte_cnt_d = 11'd1;
        word_d     = '0;
        len_err_d  = 1'b0;
        state_d    = st_hdr;
        if (rx_eof) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = st_idle;
        end
      end else begin
        case (state_q)
          st_hdr: begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (byte_cnt_q < 11'd6)   dst_d          = {dst_q[39:0], rx_byte};
            if (byte_cnt_q == 11'd12) ptype_d        = rx_byte;
            if (byte_cnt_q == 11'd13) seqnum_d[7:0]  = rx_byte;
            if (byte_cnt_q == 11'd14) seqnum_d[15:8] = rx_byte;
            if (byte_cnt_q == 11'd15) begin
              if (filter_pass) begin
                out_d.stype  = rx_start;
                out_d.header = '{ptype: ptype_q, seqnum: seqnum_q, pid: rx_byte};
                byte_cnt_d   = '0;
                word_d       = '0;
                state_d      = st_payload;
                if (rx_eof) begin
                  end_pend_d = 1'b1;
                  end_data_d = {31'd0, rx_crc_err};
                  state_d    = st_idle;
                end
              end else begin
                drop_inc = 2'd1;
                state_d  = rx_eof ? st_idle : st_drain;
              end
            end else if (rx_eof) begin
              drop_inc = 2'd1;
              state_d  = st_idle;
            end
          end
          st_payload: begin
            byte_cnt_d = cnt_inc;
            len_err_d  = len_err_q | (byte_cnt_q >= MAX_CNT);
            word_d     = word_ins;
            if (!len_err_d && ((byte_cnt_q[1:0] == 2'd3) || rx_eof)) begin
              out_d.stype = rx_data;
              out_d.data  = word_ins;
              word_d      = '0;
            end
            // rx_end waits one cycle so the flushed partial word goes first.
            if (rx_eof) begin
              end_pend_d = 1'b1;
              end_data_d = {5'd0, cnt_inc, 15'd0, rx_crc_err | len_err_d};
              state_d    = st_idle;
            end
          end
          st_drain: begin
            if (rx_eof) state_d = st_idle;
          end
          default: ;
        endcase
      end
    end

    drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= st_idle;
      byte_cnt_q <= '0;
      dst_q      <= '0;
      ptype_q    <= '0;
      seqnum_q   <= '0;
      word_q     <= '0;
      len_err_q  <= 1'b0;
      end_pend_q <= 1'b0;
      end_data_q <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      dst_q      <= dst_d;
      ptype_q    <= ptype_d;
      seqnum_q   <= seqnum_d;
      word_q     <= word_d;
      len_err_q  <= len_err_d;
      end_pend_q <= end_pend_d;
      end_data_q <= end_data_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_pipe_out = out_q;
  assign drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// tb_eth_rx_frame_parser : scoreboard bench for eth_rx_frame_parser
// Revision: 1.0
// ============================================================================
module tb_eth_rx_frame_parser;
  import eth_rx_pipe_pkg::*;

  localparam int          MAXP = 1500;
  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_05;
`ifdef ETH_RX_MAC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    eth_rx_stype_e st;
    logic [31:0]   val;
    int            cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_byte = '0;
  logic                 rx_sof = 1'b0;
  logic                 rx_eof = 1'b0;
  logic                 rx_crc_err = 1'b0;
  logic [47:0]          mac_addr = MAC;
  logic                 mac_init = 1'b1;
  eth_rx_pipe_data_type rx_pipe_out;
  logic [15:0]          drop_count;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_drop = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] ov;
  bq_t  fr;

  eth_rx_frame_parser #(.MAX_PAYLOAD(MAXP)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .rx_crc_err (rx_crc_err),
    .mac_addr   (mac_addr),
    .mac_init   (mac_init),
    .rx_pipe_out(rx_pipe_out),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every non-idle output must match the head of the scoreboard, cycle included.
  always @(negedge clk) begin
    if (!reset && rx_pipe_out.stype != rx_none) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_msg: got stype=%0d data=%h at cyc %0d, required none",
               rx_pipe_out.stype, rx_pipe_out.data, cyc);
      end
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ov = (rx_pipe_out.stype == rx_start) ? rx_pipe_out.header : rx_pipe_out.data;
        n_chk++;
        assert (rx_pipe_out.stype === e.st && ov === e.val && cyc == e.cyc) else begin
          n_fail++;
          $error("FAIL msg: got stype=%0d val=%h cyc=%0d, required stype=%0d val=%h cyc=%0d",
                 rx_pipe_out.stype, ov, cyc, e.st, e.val, e.cyc);
        end
      end
    end
  end

  function automatic void push(input eth_rx_stype_e st, input logic [31:0] v, input int c);
    exp_q.push_back('{st: st, val: v, cyc: c});
  endfunction

  function automatic bq_t mk_frame(input logic [47:0] dst, input logic [7:0] pt,
                                   input logic [7:0] s13, input logic [7:0] s14,
                                   input logic [7:0] pid, input int npay, input logic [7:0] p0);
    bq_t f;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h20 + i[7:0]);
    f.push_back(pt);
    f.push_back(s13);
    f.push_back(s14);
    f.push_back(pid);
    for (int i = 0; i < npay; i++) f.push_back(p0 + i[7:0]);
    return f;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_crc_err = 1'b0;
    end
  endtask

  // Drives one frame and records what the parser must emit for it.
  task automatic send_frame(input bq_t f, input bit crc, input bit pass,
                            input bit no_eof, input int abort_cnt);
    int n, pc;
    logic [31:0] w;
    bit le, last;
    n = f.size(); pc = 0; w = '0; le = 1'b0;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) && !no_eof;
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = f[i]; rx_sof = (i == 0); rx_eof = last;
      rx_crc_err = last & crc;
      if (i == 0 && abort_cnt >= 0) push(rx_end, {abort_cnt[15:0], 15'd0, 1'b1}, cyc + 1);
      if (pass && i == 15) push(rx_start, {f[12], f[14], f[13], f[15]}, cyc + 1);
      if (pass && i >= 16) begin
        pc++;
        if (pc > MAXP) le = 1'b1;
        else begin
          w[31-8*((pc-1)%4) -: 8] = f[i];
          if ((pc % 4 == 0) || last) begin
            push(rx_data, w, cyc + 1);
            w = '0;
          end
        end
      end
      if (pass && last && n >= 16)
        push(rx_end, {(pc > 2047 ? 16'd2047 : pc[15:0]), 15'd0, crc | le}, cyc + 2);
    end
  endtask

  task automatic check_drop(input string tag);
    n_chk++;
    assert (drop_count === exp_drop[15:0]) else begin
      n_fail++;
      $error("FAIL %s: drop_count got %0d required %0d", tag, drop_count, exp_drop);
    end
  endtask

  initial begin
    idle(3);
    n_chk++;
    assert (rx_pipe_out.stype === rx_none && rx_pipe_out.data === 32'd0 &&
            rx_pipe_out.header === '0) else begin
      n_fail++;
      $error("FAIL reset_out: got stype=%0d data=%h, required 0/0", rx_pipe_out.stype, rx_pipe_out.data);
    end
    check_drop("reset_drop");
    @(negedge clk) reset = 1'b0;
    idle(2);

    // Basic frame: seqnum wire image 12,34 -> 16'h3412, two full words, count 8.
    push(rx_start, {rstPacketType, 16'h3412, 8'h10}, -1);
    void'(exp_q.pop_back());
    send_frame(mk_frame(MAC, rstPacketType, 8'h12, 8'h34, 8'h10, 8, 8'h01), 1'b0, 1'b1, 1'b0, -1);
    idle(4);

    // CRC error with partial word AA BB.
    send_frame(mk_frame(MAC, 8'h05, 8'h01, 8'h00, 8'h22, 2, 8'hAA), 1'b1, 1'b1, 1'b0, -1);
    idle(4);

    // Runt.
    fr = mk_frame(MAC, 8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    while (fr.size() > 10) void'(fr.pop_back());
    send_frame(fr, 1'b0, 1'b1, 1'b0, -1);
    idle(3);
    exp_drop++;
    check_drop("runt_drop");

    // Foreign destination, then broadcast.
    send_frame(mk_frame(48'h02_00_00_00_00_09, 8'h05, 8'h03, 8'h00, 8'h33, 5, 8'h40), 1'b0, !FILT, 1'b0, -1);
    idle(3);
    exp_drop += int'(FILT);
    check_drop("filter_drop");
    send_frame(mk_frame(48'hFFFF_FFFF_FFFF, 8'h07, 8'h04, 8'h00, 8'h44, 3, 8'h50), 1'b0, 1'b1, 1'b0, -1);
    idle(3);
    check_drop("bcast_drop");

    // Abort mid-payload after 6 bytes; new frame follows immediately.
    send_frame(mk_frame(MAC, 8'h05, 8'h05, 8'h00, 8'h55, 6, 8'h60), 1'b0, 1'b1, 1'b1, -1);
    send_frame(mk_frame(MAC, 8'h06, 8'h06, 8'h00, 8'h66, 5, 8'h70), 1'b0, 1'b1, 1'b0, 6);
    idle(3);
    check_drop("abort_payload_drop");

    // Zero payload, then a back-to-back frame.
    send_frame(mk_frame(MAC, 8'h08, 8'h07, 8'h01, 8'h77, 0, 8'h00), 1'b0, 1'b1, 1'b0, -1);
    send_frame(mk_frame(MAC, 8'h09, 8'h08, 8'h02, 8'h88, 4, 8'h80), 1'b0, 1'b1, 1'b0, -1);
    idle(3);

    // SOF in the header aborts and counts.
    fr = mk_frame(MAC, 8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    while (fr.size() > 8) void'(fr.pop_back());
    send_frame(fr, 1'b0, 1'b1, 1'b1, -1);
    send_frame(mk_frame(MAC, 8'h0A, 8'h09, 8'h00, 8'h99, 7, 8'h90), 1'b0, 1'b1, 1'b0, -1);
    idle(3);
    exp_drop++;
    check_drop("abort_hdr_drop");

    // Reset at payload byte 3: nothing further may appear.
    send_frame(mk_frame(MAC, 8'h05, 8'h0A, 8'h00, 8'hAA, 2, 8'hA0), 1'b0, 1'b1, 1'b1, -1);
    @(negedge clk);
    rx_valid = 1'b0; rx_sof = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_chk++;
    assert (rx_pipe_out.stype === rx_none) else begin
      n_fail++;
      $error("FAIL reset_mid_out: got stype=%0d required %0d", rx_pipe_out.stype, rx_none);
    end
    reset = 1'b0;
    exp_drop = 0;
    idle(20);
    check_drop("reset_mid_drop");

    // Oversize payload.
    send_frame(mk_frame(MAC, 8'h05, 8'h0B, 8'h00, 8'hBB, MAXP + 1, 8'h00), 1'b0, 1'b1, 1'b0, -1);
    idle(5);

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_msgs: got %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
